aes_enc_iter: RTL and testbench

Iterative AES block encryptor, parametrised for AES-128 or AES-256, with valid/ready handshakes on input and output. Performs one full round per clock and expands the key on the fly: one key-schedule step per round, no stored round-key table. It replaces the fixed-width, free-running top-level encryptor; upstream it connects to a block source, downstream to a ciphertext sink.

---
 rtl/aes_pkg.sv | 117 +++++++++++
 rtl/aes_key_step.sv | 43 ++++
 rtl/aes_enc_iter.sv | 127 ++++++++++++
 tb/tb_aes_enc_iter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : AES primitives (S-box, xtime, round transforms, Rcon, FSM enum)
// Revision    : 1.0
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] v;
        case (idx)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) begin
            o[8*n +: 8] = sbox(s[8*n +: 8]);
        end
        return o;
    endfunction

    // Byte n of the block sits at bits [127-8n -: 8]; state row r, column c is byte r+4c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_step.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_step
// Description : Combinational key-schedule step, next four words from window
// Revision    : 1.0
// ============================================================================
module aes_key_step
    import aes_pkg::*;
#(
    parameter int KEY_WORDS = 4
) (
    input  logic [32*KEY_WORDS-1:0] i_w,
    input  logic [5:0]              i_idx,
    output logic [127:0]            o_words
);

    localparam int KW_BITS = 32 * KEY_WORDS;

    logic        w_mod0;
    logic [3:0]  w_rcon_idx;
    logic [31:0] w_last;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;
    logic        w_unused;

    assign w_mod0     = (i_idx & 6'(KEY_WORDS - 1)) == 6'd0;
    assign w_rcon_idx = 4'(i_idx / 6'(KEY_WORDS));
    assign w_last     = i_w[31:0];
    assign w_unused   = ^i_w;

    // With 8-word keys the off-boundary step (i mod 8 == 4) uses SubWord alone.
    assign w_temp = w_mod0 ? (sub_word(rot_word(w_last)) ^ {rcon(w_rcon_idx), 24'h000000})
                           : sub_word(w_last);

    assign w_n0 = i_w[KW_BITS-1  -: 32] ^ w_temp;
    assign w_n1 = i_w[KW_BITS-33 -: 32] ^ w_n0;
    assign w_n2 = i_w[KW_BITS-65 -: 32] ^ w_n1;
    assign w_n3 = i_w[KW_BITS-97 -: 32] ^ w_n2;

    assign o_words = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_enc_iter.sv
`default_nettype none
// ============================================================================
// Module      : aes_enc_iter
// Description : Iterative AES-128/256 encryptor, one round per clock
// Revision    : 1.0
// ============================================================================
module aes_enc_iter
    import aes_pkg::*;
#(
    parameter int KEY_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            plaintext,
    input  logic [32*KEY_WORDS-1:0] key,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            ciphertext,
    output logic                    busy
);

    localparam int         KW_BITS = 32 * KEY_WORDS;
    localparam logic [3:0] C_NR    = 4'(KEY_WORDS + 6);

    generate
        if (!(KEY_WORDS == 4 || KEY_WORDS == 8)) begin : g_bad_key_words
            $error("aes_enc_iter: KEY_WORDS must be 4 or 8");
        end
    endgenerate

    aes_state_t         r_state;
    aes_state_t         w_state_nxt;
    logic [127:0]       r_s;
    logic [KW_BITS-1:0] r_w;
    logic [3:0]         r_rnd;

    logic [5:0]         w_idx;
    logic [127:0]       w_step;
    logic [127:0]       w_rkey;
    logic [KW_BITS-1:0] w_w_adv;
    logic [127:0]       w_sr;
    logic [127:0]       w_mc;
    logic [127:0]       w_round;
    logic               w_last_rnd;

    assign w_last_rnd = (r_rnd == C_NR);

    aes_key_step #(
        .KEY_WORDS(KEY_WORDS)
    ) u_key_step (
        .i_w    (r_w),
        .i_idx  (w_idx),
        .o_words(w_step)
    );

    // AES-256 keeps the current round key in the window; AES-128 derives it this cycle.
    generate
        if (KEY_WORDS == 8) begin : g_kw8
            assign w_idx   = {r_rnd, 2'b00} + 6'd4;
            assign w_rkey  = r_w[127:0];
            assign w_w_adv = {r_w[127:0], w_step};
        end else begin : g_kw4
            assign w_idx   = {r_rnd, 2'b00};
            assign w_rkey  = w_step;
            assign w_w_adv = w_step;
        end
    endgenerate

    assign w_sr    = shift_rows(sub_bytes(r_s));
    assign w_mc    = mix_columns(w_sr);
    assign w_round = (w_last_rnd ? w_sr : w_mc) ^ w_rkey;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)   w_state_nxt = RUN;
            RUN:     if (w_last_rnd) w_state_nxt = DONE;
            DONE:    if (out_ready)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s   <= '0;
            r_w   <= '0;
            r_rnd <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_s   <= plaintext ^ key[KW_BITS-1 -: 128];
                        r_w   <= key;
                        r_rnd <= 4'd1;
                    end
                end
                RUN: begin
                    r_s <= w_round;
                    r_w <= w_w_adv;
                    if (!w_last_rnd) r_rnd <= r_rnd + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign ciphertext = r_s;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_enc_iter
// Description : Self-checking bench for aes_enc_iter (AES-128 and AES-256)
// Revision    : 1.0
// ============================================================================
module tb_aes_enc_iter;

    typedef struct {
        int           kw;
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;

    logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [127:0] pt4, key4, ct4;
    logic         in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [127:0] pt8, ct8;
    logic [255:0] key8;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[3];

    always #5 clk = ~clk;

    aes_enc_iter #(.KEY_WORDS(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .plaintext(pt4), .key(key4), .out_valid(out_valid4), .out_ready(out_ready4),
        .ciphertext(ct4), .busy(busy4)
    );

    aes_enc_iter #(.KEY_WORDS(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .plaintext(pt8), .key(key8), .out_valid(out_valid8), .out_ready(out_ready8),
        .ciphertext(ct8), .busy(busy8)
    );

    function automatic logic f_ov(input int kw);
        return (kw == 4) ? out_valid4 : out_valid8;
    endfunction

    function automatic logic f_ir(input int kw);
        return (kw == 4) ? in_ready4 : in_ready8;
    endfunction

    function automatic logic [127:0] f_ct(input int kw);
        return (kw == 4) ? ct4 : ct8;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int kw, input logic v, input logic [127:0] pt, input logic [255:0] k);
        if (kw == 4) begin
            in_valid4 = v; pt4 = pt; key4 = k[255:128];
        end else begin
            in_valid8 = v; pt8 = pt; key8 = k;
        end
    endtask

    task automatic run_block(input vec_t v, input bit scramble, input string nm);
        int wt;
        int lat;
        @(negedge clk);
        drive(v.kw, 1'b1, v.pt, v.key);
        wt = 0;
        while (!f_ir(v.kw) && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        chki({nm, " accept"}, int'(wt < 50), 1);
        @(posedge clk);
        @(negedge clk);
        if (scramble)
            drive(v.kw, 1'b0, {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        else
            drive(v.kw, 1'b0, v.pt, v.key);
        lat = 1;
        while (!f_ov(v.kw) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chki({nm, " latency"}, lat, v.lat);
        chk({nm, " ciphertext"}, f_ct(v.kw), v.ct);
        @(negedge clk);
        chki({nm, " idle after out"}, int'(f_ir(v.kw)), 1);
    endtask

    initial begin
        logic [127:0] cap;
        int wt, lat, bad, acc_n;
        int acc[2];

        vecs[0] = '{4, 128'h3243f6a8885a308d313198a2e0370734,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32, 11};
        vecs[1] = '{4, 128'h00112233445566778899aabbccddeeff,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 11};
        vecs[2] = '{8, 128'h00112233445566778899aabbccddeeff,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 15};

        reset = 1'b1;
        drive(4, 1'b0, '0, '0);
        drive(8, 1'b0, '0, '0);
        out_ready4 = 1'b1;
        out_ready8 = 1'b1;
        repeat (3) @(negedge clk);

        chki("reset in_ready4", int'(in_ready4), 1);
        chki("reset out_valid4", int'(out_valid4), 0);
        chk("reset ct4", ct4, '0);
        chki("reset busy4", int'(busy4), 0);
        chki("reset in_ready8", int'(in_ready8), 1);
        chki("reset out_valid8", int'(out_valid8), 0);
        chk("reset ct8", ct8, '0);
        chki("reset busy8", int'(busy8), 0);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        run_block(vecs[0], 1'b1, "stable_inputs");
        run_block(vecs[2], 1'b1, "stable_inputs256");

        // Backpressure: result held in DONE while the sink refuses it.
        @(negedge clk);
        out_ready4 = 1'b0;
        drive(4, 1'b1, vecs[1].pt, vecs[1].key);
        wt = 0;
        while (!in_ready4 && wt < 50) begin @(negedge clk); wt++; end
        @(posedge clk);
        @(negedge clk);
        drive(4, 1'b0, vecs[1].pt, vecs[1].key);
        lat = 1;
        while (!out_valid4 && lat < 40) begin @(negedge clk); lat++; end
        chki("bp latency", lat, 11);
        cap = ct4;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid4 || ct4 !== cap || in_ready4 || !busy4) bad++;
        end
        chki("bp held cycles bad", bad, 0);
        chk("bp ciphertext", ct4, vecs[1].ct);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        chki("bp in_ready after pulse", int'(in_ready4), 1);
        chki("bp out_valid after pulse", int'(out_valid4), 0);
        out_ready4 = 1'b1;

        // Back-to-back blocks with in_valid held high.
        @(negedge clk);
        drive(4, 1'b1, vecs[0].pt, vecs[0].key);
        acc_n = 0;
        for (int j = 0; j < 60 && acc_n < 2; j++) begin
            if (in_valid4 && in_ready4) begin
                acc[acc_n] = j;
                acc_n++;
            end
            @(negedge clk);
        end
        drive(4, 1'b0, vecs[0].pt, vecs[0].key);
        chki("b2b accepts", acc_n, 2);
        chki("b2b period", (acc_n == 2) ? acc[1] - acc[0] : -1, 12);
        lat = 0;
        while (!out_valid4 && lat < 40) begin @(negedge clk); lat++; end
        chk("b2b second ciphertext", ct4, vecs[0].ct);
        @(negedge clk);

        // Asynchronous reset in the middle of round 5.
        @(negedge clk);
        drive(4, 1'b1, vecs[0].pt, vecs[0].key);
        wt = 0;
        while (!in_ready4 && wt < 50) begin @(negedge clk); wt++; end
        @(posedge clk);
        repeat (5) @(negedge clk);
        chki("rst pre busy", int'(busy4), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst ct immediate", ct4, '0);
        chki("rst out_valid immediate", int'(out_valid4), 0);
        chki("rst busy immediate", int'(busy4), 0);
        chki("rst in_ready immediate", int'(in_ready4), 1);
        repeat (2) @(negedge clk);
        drive(4, 1'b0, vecs[0].pt, vecs[0].key);
        reset = 1'b0;
        chki("rst in_valid ignored", int'(busy4), 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid4) bad++;
        end
        chki("rst no out_valid", bad, 0);
        run_block(vecs[0], 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
